// File: rtl/mpc_cycle_supervisor.sv
// mpc_cycle_supervisor: launches the solver each period, watchdogs it, counts overruns and holds its output
module mpc_cycle_supervisor #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic              hold_sync,
  input  logic [31:0]       timeout_cycles,
  input  logic              clear_stats,
  input  logic              solver_done,
  input  logic [DATA_W-1:0] solver_u,
  output logic              solver_start,
  output logic              solver_abort,
  output logic              busy,
  output logic [DATA_W-1:0] u_hold,
  output logic              u_valid,
  output logic              u_update,
  output logic [31:0]       last_latency,
  output logic [31:0]       max_latency,
  output logic [15:0]       overrun_count,
  output logic              timeout_flag
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [31:0] lat_q, lat_d, last_latency_q, last_latency_d, max_latency_q, max_latency_d;
  logic [DATA_W-1:0] u_hold_q, u_hold_d, u_pend_q, u_pend_d;
  logic [15:0] overrun_count_q, overrun_count_d;
  logic pend_valid_q, pend_valid_d, u_valid_q, u_valid_d, u_update_q, u_update_d;
  logic solver_start_q, solver_start_d, solver_abort_q, solver_abort_d;
  logic timeout_flag_q, timeout_flag_d;
  // next-state: launch from IDLE, then done / watchdog / overrun handling while waiting
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    last_latency_d = last_latency_q;
    max_latency_d = max_latency_q;
    u_hold_d = u_hold_q;
    u_pend_d = u_pend_q;
    overrun_count_d = overrun_count_q;
    pend_valid_d = pend_valid_q;
    u_valid_d = u_valid_q;
    timeout_flag_d = timeout_flag_q;
    u_update_d = 1'b0;
    solver_start_d = 1'b0;
    solver_abort_d = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        solver_start_d = 1'b1;
        lat_d = '0;
        state_d = WAIT;
        if (hold_sync && pend_valid_q) begin
          u_hold_d = u_pend_q;
          u_update_d = 1'b1;
          u_valid_d = 1'b1;
          pend_valid_d = 1'b0;
        end
      end
    end else if (solver_done) begin
      last_latency_d = lat_q;
      max_latency_d = (lat_q > max_latency_q) ? lat_q : max_latency_q;
      if (start) begin
        // back-to-back period: the result is applied now, no pending slot needed
        solver_start_d = 1'b1;
        lat_d = '0;
        u_hold_d = solver_u;
        u_update_d = 1'b1;
        u_valid_d = 1'b1;
        pend_valid_d = 1'b0;
      end else begin
        state_d = IDLE;
        if (hold_sync) begin
          u_pend_d = solver_u;
          pend_valid_d = 1'b1;
        end else begin
          u_hold_d = solver_u;
          u_update_d = 1'b1;
          u_valid_d = 1'b1;
        end
      end
    end else begin
      if (start && overrun_count_q != 16'hFFFF) overrun_count_d = overrun_count_q + 16'd1;
      if (timeout_cycles != 32'd0 && lat_q == timeout_cycles - 32'd1) begin
        solver_abort_d = 1'b1;
        timeout_flag_d = 1'b1;
        state_d = IDLE;
      end else begin
        lat_d = lat_q + 32'd1;
      end
    end
    if (clear_stats) begin
      overrun_count_d = '0;
      timeout_flag_d = 1'b0;
      max_latency_d = '0;
      last_latency_d = '0;
    end
  end
  // state register: reset overrides ce, everything holds while ce is low
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q <= '0;
      last_latency_q <= '0;
      max_latency_q <= '0;
      u_hold_q <= '0;
      u_pend_q <= '0;
      overrun_count_q <= '0;
      pend_valid_q <= 1'b0;
      u_valid_q <= 1'b0;
      u_update_q <= 1'b0;
      solver_start_q <= 1'b0;
      solver_abort_q <= 1'b0;
      timeout_flag_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      lat_q <= lat_d;
      last_latency_q <= last_latency_d;
      max_latency_q <= max_latency_d;
      u_hold_q <= u_hold_d;
      u_pend_q <= u_pend_d;
      overrun_count_q <= overrun_count_d;
      pend_valid_q <= pend_valid_d;
      u_valid_q <= u_valid_d;
      u_update_q <= u_update_d;
      solver_start_q <= solver_start_d;
      solver_abort_q <= solver_abort_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end
  assign busy = (state_q == WAIT);
  assign solver_start = solver_start_q;
  assign solver_abort = solver_abort_q;
  assign u_hold = u_hold_q;
  assign u_valid = u_valid_q;
  assign u_update = u_update_q;
  assign last_latency = last_latency_q;
  assign max_latency = max_latency_q;
  assign overrun_count = overrun_count_q;
  assign timeout_flag = timeout_flag_q;
endmodule

// File: tb/tb_mpc_cycle_supervisor.sv
// tb_mpc_cycle_supervisor: directed plus random stimulus, scoreboarded against a launch-time based reference model
module tb_mpc_cycle_supervisor;
  logic clk = 1'b0, reset, ce, start, hold_sync, clear_stats, solver_done;
  logic [31:0] timeout_cycles, solver_u;
  logic solver_start, solver_abort, busy, u_valid, u_update, timeout_flag;
  logic [31:0] u_hold, last_latency, max_latency;
  logic [15:0] overrun_count;

  mpc_cycle_supervisor #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .ce(ce), .start(start), .hold_sync(hold_sync),
    .timeout_cycles(timeout_cycles), .clear_stats(clear_stats), .solver_done(solver_done),
    .solver_u(solver_u), .solver_start(solver_start), .solver_abort(solver_abort), .busy(busy),
    .u_hold(u_hold), .u_valid(u_valid), .u_update(u_update), .last_latency(last_latency),
    .max_latency(max_latency), .overrun_count(overrun_count), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic s_start, s_abort, busy, uv, upd, tflag;
    logic [31:0] u, last, maxl;
    logic [15:0] ovr;
  } snap_t;

  snap_t exp_q[$];
  int tests = 0, fails = 0;
  bit first = 1'b1;

  // reference model: latency is the number of ce cycles elapsed since the launch cycle
  snap_t m;
  logic [31:0] ce_n = 0, launch_n = 0, m_pend = 0;
  logic m_pendv = 1'b0;

  task automatic model(input logic r, c, s, h, input logic [31:0] t, input logic cl, d, input logic [31:0] u);
    logic [31:0] el;
    if (r) begin
      m = '0; m_pend = '0; m_pendv = 1'b0;
    end else if (c) begin
      el = ce_n - launch_n;
      m.s_start = 1'b0; m.s_abort = 1'b0; m.upd = 1'b0;
      if (!m.busy) begin
        if (s) begin
          m.s_start = 1'b1; m.busy = 1'b1; launch_n = ce_n + 1;
          if (h && m_pendv) begin m.u = m_pend; m.upd = 1'b1; m.uv = 1'b1; m_pendv = 1'b0; end
        end
      end else if (d) begin
        m.last = el;
        if (el > m.maxl) m.maxl = el;
        if (s) begin
          m.s_start = 1'b1; launch_n = ce_n + 1; m.u = u; m.upd = 1'b1; m.uv = 1'b1; m_pendv = 1'b0;
        end else begin
          m.busy = 1'b0;
          if (h) begin m_pend = u; m_pendv = 1'b1; end
          else begin m.u = u; m.upd = 1'b1; m.uv = 1'b1; end
        end
      end else begin
        if (s && m.ovr != 16'hFFFF) m.ovr = m.ovr + 1;
        if (t != 0 && el == t - 1) begin m.s_abort = 1'b1; m.tflag = 1'b1; m.busy = 1'b0; end
      end
      if (cl) begin m.ovr = 0; m.tflag = 0; m.maxl = 0; m.last = 0; end
      ce_n = ce_n + 1;
    end
  endtask

  task automatic cyc(input logic r, c, s, h, input logic [31:0] t, input logic cl, d, input logic [31:0] u);
    if (!first) @(negedge clk);
    first = 1'b0;
    reset = r; ce = c; start = s; hold_sync = h; timeout_cycles = t;
    clear_stats = cl; solver_done = d; solver_u = u;
    model(r, c, s, h, t, cl, d, u);
    exp_q.push_back(m);
  endtask

  logic cur_h = 1'b0;
  logic [31:0] cur_t = 32'd100;

  task automatic go(input logic s, d, input logic [31:0] u);
    cyc(1'b0, 1'b1, s, cur_h, cur_t, 1'b0, d, u);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) go(1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // monitor: every clock edge presents a new output state, compared against the oldest prediction
  initial forever begin
    snap_t e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("solver_start", {31'b0, solver_start}, {31'b0, e.s_start});
      chk("solver_abort", {31'b0, solver_abort}, {31'b0, e.s_abort});
      chk("busy", {31'b0, busy}, {31'b0, e.busy});
      chk("u_valid", {31'b0, u_valid}, {31'b0, e.uv});
      chk("u_update", {31'b0, u_update}, {31'b0, e.upd});
      chk("timeout_flag", {31'b0, timeout_flag}, {31'b0, e.tflag});
      chk("u_hold", u_hold, e.u);
      chk("last_latency", last_latency, e.last);
      chk("max_latency", max_latency, e.maxl);
      chk("overrun_count", {16'b0, overrun_count}, {16'b0, e.ovr});
    end
  end

  initial begin
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'd100, 1'b0, 1'b0, 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd100, 1'b0, 1'b0, 32'h0);
    idle(3);
    go(1'b1, 1'b0, 0); idle(5); go(1'b0, 1'b1, 32'h1234); idle(3);
    cur_h = 1'b1;
    go(1'b1, 1'b0, 0); idle(5); go(1'b0, 1'b1, 32'hABCD); idle(10);
    go(1'b1, 1'b0, 0); idle(3);
    go(1'b1, 1'b1, 32'h5555);
    go(1'b0, 1'b1, 32'h6666); idle(2);
    cur_h = 1'b0;
    go(1'b1, 1'b0, 0); idle(9); go(1'b1, 1'b0, 0); idle(3); go(1'b0, 1'b1, 32'h7777); idle(2);
    cur_t = 32'd8;
    go(1'b1, 1'b0, 0); idle(12);
    cyc(1'b0, 1'b1, 1'b0, cur_h, cur_t, 1'b1, 1'b0, 0); idle(2);
    cur_t = 32'd0;
    go(1'b1, 1'b0, 0); idle(3);
    cyc(1'b1, 1'b1, 1'b0, cur_h, cur_t, 1'b0, 1'b0, 0);
    go(1'b0, 1'b1, 32'h9999); idle(2);
    go(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) cyc(1'b0, i[0], 1'b0, cur_h, cur_t, 1'b0, 1'b0, 0);
    go(1'b0, 1'b1, 32'h4242); idle(2);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) cur_h = ~cur_h;
      if ($urandom_range(0, 49) == 0) cur_t = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 6) == 0, cur_h, cur_t,
          $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom);
    end
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mpc_cycle_supervisor.md
# mpc_cycle_supervisor

Supervises each control cycle of the MPC solver. It sits directly downstream of the period/start generator and directly upstream of the solver core and the actuator output. It turns each periodic start pulse into a solver launch, watches the solver's done handshake with a watchdog, and counts overruns. It also latches the solver's control output into a zero-order-hold register, applied either on solver completion or at the next sampling instant.

## Interface
- DATA_W, 32, width of solver control output / held output
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; overrides ce
- ce  in  1  clock enable; registers update and inputs are sampled only when ce=1
- start  in  1  period pulse from start generator, 1 ce-cycle wide
- hold_sync  in  1  1: apply result at next start; 0: apply on done
- timeout_cycles  in  32  watchdog limit in ce-cycles; 0 = disabled
- clear_stats  in  1  clears overrun_count, timeout_flag, max_latency, last_latency
- solver_done  in  1  solver completion, sampled only in WAIT
- solver_u  in  DATA_W  solver result, valid when solver_done=1
- solver_start  out  1  registered launch pulse to solver
- solver_abort  out  1  registered abort pulse on watchdog expiry
- busy  out  1  1 while in WAIT
- u_hold  out  DATA_W  zero-order-held control output
- u_valid  out  1  sticky; set on first u_hold load
- u_update  out  1  1-cycle pulse when u_hold is loaded
- last_latency  out  32  ce-cycles from launch to done, last completed cycle
- max_latency  out  32  maximum of last_latency since clear/reset
- overrun_count  out  16  starts received while busy, saturates at 16'hFFFF
- timeout_flag  out  1  sticky watchdog-expiry flag

## Operation
- Reset value of every output and internal register is 0, and state=IDLE. This covers pend_valid, u_pend and the latency counter lat.
- Pulses (solver_start, solver_abort, u_update) default to 0 on each ce cycle. They are high for exactly one ce cycle. With ce=0 they hold.
- FSM states: IDLE, WAIT.
- IDLE, start=1:
  - solver_start<=1, lat<=0, state<=WAIT.
  - If hold_sync=1 and pend_valid=1: u_hold<=u_pend, u_update<=1, u_valid<=1, pend_valid<=0.
- WAIT, each ce cycle, evaluated in this priority order:
  1. solver_done=1:
     - last_latency<=lat; max_latency<=max(max_latency, lat).
     - hold_sync=0: u_hold<=solver_u, u_update<=1, u_valid<=1.
     - hold_sync=1: u_pend<=solver_u, pend_valid<=1.
     - If start=1 in the same cycle, this is a fresh launch, not an overrun. solver_start<=1, lat<=0, stay WAIT. With hold_sync=1, u_hold<=solver_u directly and pend_valid stays 0.
     - Otherwise state<=IDLE.
  2. timeout_cycles!=0 and lat==timeout_cycles-1:
     - solver_abort<=1, timeout_flag<=1, state<=IDLE.
     - u_pend and u_hold are unchanged.
     - A start in this cycle counts as an overrun and is not launched.
  3. Otherwise lat<=lat+1.
     - A start in this cycle increments overrun_count (saturating). It is ignored for launch. The solver keeps running and u_hold is not reloaded.
- clear_stats=1 clears all stats. If a stat update happens in the same cycle, clear_stats wins. clear_stats does not affect the FSM, u_hold or pend_valid.
- lat is 32-bit and wraps naturally. With timeout disabled, wrap is the accepted behaviour.

## Timing
- Launch latency: start sampled in cycle N gives solver_start high in N+1. busy is high from N+1.
- Latency definition: solver_start high in cycle T and solver_done sampled in cycle T+k gives last_latency=k. k=0 is legal.
- Output update timing:
  - hold_sync=0: u_hold is valid one cycle after solver_done.
  - hold_sync=1: u_hold is valid one cycle after the next accepted start. This gives a constant one-period actuation delay.
- Watchdog: with timeout_cycles=L and solver_start at T, solver_abort is high at T+L. busy is low from T+L.
- Reset mid-WAIT returns the block to IDLE next cycle, with all outputs 0. A solver_done arriving afterwards is ignored.

## Test plan
- **Basic launch, hold_sync=0.** timeout_cycles=100; start at cycle 10; solver_done with solver_u=32'h1234 at cycle 16 (solver_start at 11). Required: solver_start@11; u_hold=1234 and u_update@17; last_latency=5; busy low@17.
- **Synchronous hold, hold_sync=1.** Same as above, next start at cycle 40. Required: u_hold stays 0 until cycle 41, then 32'h1234 with u_update@41; solver_start@41.
- **Overrun.** Start at 10; second start at 20 with no done. Required: overrun_count=1@21; no solver_start@21; a later done still captures.
- **Watchdog.** timeout_cycles=8; start at 10; no done. Required: solver_abort and timeout_flag@19; busy 0@19; u_hold unchanged. Then clear_stats: timeout_flag=0.
- **Simultaneous done+start in WAIT, hold_sync=1.** Required: u_hold=solver_u with u_update next cycle; solver_start next cycle; overrun_count unchanged; busy stays 1.
- **Reset and ce.**
  - Reset asserted in WAIT: all outputs 0 next cycle.
  - With ce toggling 1/0: latency counts only ce=1 cycles, and solver_start persists across ce=0 cycles.
